// File: rtl/rk4_controller.sv
// rtl/rk4_controller.sv - fixed-step RK4 integrator sequencer driving a shared external slope evaluator
// Q16.16 datapath; one evaluator operand set per stage, sequential divide by 6 per step.
module rk4_controller #(
  parameter int n       = 32,
  parameter int H_SHIFT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [n-1:0] x0,
  input  logic [n-1:0] y0,
  input  logic [15:0]  n_steps,
  output logic [n-1:0] fx,
  output logic [n-1:0] fy,
  output logic [n-1:0] fh,
  output logic [n-1:0] fk,
  input  logic [n-1:0] f_dydx,
  output logic [n-1:0] x_out,
  output logic [n-1:0] y_out,
  output logic         step_valid,
  output logic         busy,
  output logic         done
);

  localparam int SW = n + 3;
  localparam logic [n-1:0] H = {{(n-1){1'b0}}, 1'b1} << (16 - H_SHIFT);
  localparam logic [5:0] DIV_LAST = 6'(SW - 1);

  typedef enum logic [3:0] {
    IDLE, K1I, K1C, K2I, K2C, K3I, K3C, K4I, K4C, SUM, DIV, UPDATE
  } state_t;

  state_t state, state_nx;

  logic [n-1:0]        x, y;
  logic signed [n-1:0] k1, k2, k3, k4;
  logic [15:0]         steps_left;
  logic [SW-1:0]       mag;
  logic [3:0]          rem;
  logic [5:0]          div_cnt;
  logic                neg;

  logic signed [SW-1:0] k1_w, k2_w, k3_w, k4_w, s_sum, t_val;
  logic [SW-1:0]        t_mag;
  logic [4:0]           trial;
  logic                 quo_bit;
  logic [3:0]           rem_nx;
  logic [n-1:0]         q_lo, delta, x_nx, y_nx;

  // Weighted slope sum cannot overflow SW bits: |S| <= 6 * 2^(n-1).
  assign k1_w  = {{(SW-n){k1[n-1]}}, k1};
  assign k2_w  = {{(SW-n){k2[n-1]}}, k2};
  assign k3_w  = {{(SW-n){k3[n-1]}}, k3};
  assign k4_w  = {{(SW-n){k4[n-1]}}, k4};
  assign s_sum = k1_w + (k2_w <<< 1) + (k3_w <<< 1) + k4_w;
  assign t_val = s_sum >>> H_SHIFT;
  assign t_mag = t_val[SW-1] ? -t_val : t_val;

  // Restoring divide by 6: remainder stays below 6, so 4 bits suffice.
  assign trial   = {rem, mag[SW-1]};
  assign quo_bit = (trial >= 5'd6);
  assign rem_nx  = quo_bit ? 4'(trial - 5'd6) : trial[3:0];

  assign q_lo  = mag[n-1:0];
  assign delta = neg ? -q_lo : q_lo;
  assign x_nx  = x + H;
  assign y_nx  = y + delta;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fx = '0;
    fy = '0;
    fh = '0;
    fk = '0;
    case (state)
      IDLE:    if (start && n_steps != 16'd0) state_nx = K1I;
      K1I:     state_nx = K1C;
      K1C:     state_nx = K2I;
      K2I:     state_nx = K2C;
      K2C:     state_nx = K3I;
      K3I:     state_nx = K3C;
      K3C:     state_nx = K4I;
      K4I:     state_nx = K4C;
      K4C:     state_nx = SUM;
      SUM:     state_nx = DIV;
      DIV:     if (div_cnt == DIV_LAST) state_nx = UPDATE;
      UPDATE:  state_nx = (steps_left == 16'd1) ? IDLE : K1I;
      default: state_nx = IDLE;
    endcase
    if (abort && state != IDLE) state_nx = IDLE;

    case (state)
      K1I, K1C: begin
        fx = x;
        fy = y;
      end
      K2I, K2C: begin
        fx = x;
        fy = y;
        fh = H >> 1;
        fk = k1 >>> (H_SHIFT + 1);
      end
      K3I, K3C: begin
        fx = x;
        fy = y;
        fh = H >> 1;
        fk = k2 >>> (H_SHIFT + 1);
      end
      K4I, K4C: begin
        fx = x;
        fy = y;
        fh = H;
        fk = k3 >>> H_SHIFT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x          <= '0;
      y          <= '0;
      x_out      <= '0;
      y_out      <= '0;
      k1         <= '0;
      k2         <= '0;
      k3         <= '0;
      k4         <= '0;
      steps_left <= '0;
      mag        <= '0;
      rem        <= '0;
      div_cnt    <= '0;
      neg        <= 1'b0;
      done       <= 1'b0;
      step_valid <= 1'b0;
    end else begin
      done       <= 1'b0;
      step_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x          <= x0;
            y          <= y0;
            steps_left <= n_steps;
            if (n_steps == 16'd0) begin
              x_out <= x0;
              y_out <= y0;
              done  <= 1'b1;
            end
          end
        end
        K1C: k1 <= f_dydx;
        K2C: k2 <= f_dydx;
        K3C: k3 <= f_dydx;
        K4C: k4 <= f_dydx;
        SUM: begin
          mag     <= t_mag;
          neg     <= t_val[SW-1];
          rem     <= '0;
          div_cnt <= '0;
        end
        DIV: begin
          mag     <= {mag[SW-2:0], quo_bit};
          rem     <= rem_nx;
          div_cnt <= div_cnt + 6'd1;
        end
        UPDATE: begin
          // An abort landing on UPDATE drops the step entirely.
          if (!abort) begin
            x          <= x_nx;
            y          <= y_nx;
            x_out      <= x_nx;
            y_out      <= y_nx;
            steps_left <= steps_left - 16'd1;
            step_valid <= 1'b1;
            done       <= (steps_left == 16'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rk4_controller.sv
// tb/tb_rk4_controller.sv - directed bench for rk4_controller with a behavioural slope evaluator
// Evaluator computes f = (fx + fh - fy - fk) >>> 1, or a constant -1.0 when force_neg is set.
module tb_rk4_controller;

  logic clk = 1'b0;
  logic reset_n, start, abort, force_neg;
  logic [31:0] x0, y0, fx, fy, fh, fk, f_dydx, x_out, y_out;
  logic [15:0] n_steps;
  logic step_valid, busy, done;
  logic signed [31:0] ev_sum;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] x0;
    logic [31:0] y0;
    logic [15:0] n;
    logic        neg;
    logic [31:0] ex;
    logic [31:0] ey;
    int          tol;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  rk4_controller #(.n(32), .H_SHIFT(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .n_steps(n_steps),
    .fx(fx), .fy(fy), .fh(fh), .fk(fk), .f_dydx(f_dydx),
    .x_out(x_out), .y_out(y_out),
    .step_valid(step_valid), .busy(busy), .done(done)
  );

  always_comb begin
    ev_sum = $signed(fx) + $signed(fh) - $signed(fy) - $signed(fk);
    f_dydx = force_neg ? 32'hFFFF_0000 : 32'(ev_sum >>> 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
    int diff;
    diff = $signed(act - exp);
    checks++;
    if ($isunknown(act) || diff > tol || diff < -tol) begin
      failures++;
      $display("FAIL %s: got %h expected %h +/- %0d", name, act, exp, tol);
    end
  endtask

  // Called at the negedge of the first cycle after the accepting edge.
  task automatic monitor_run(input string tag, input logic [31:0] vx0, input logic [31:0] vy0,
                             input int n, input logic [31:0] ex, input logic [31:0] ey, input int tol);
    int nvalid, ndone, first_sv, last_sv, gap_bad, busy_hi, done_cyc, budget;
    nvalid = 0; ndone = 0; first_sv = -1; last_sv = -1;
    gap_bad = 0; busy_hi = 0; done_cyc = -1;
    budget = 45 * n + 6;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (n > 0 && cyc == 1) begin
        chk({tag, "_k1i_fx"}, fx, vx0);
        chk({tag, "_k1i_fy"}, fy, vy0);
        chk({tag, "_k1i_fh"}, fh, 32'h0);
      end
      if (n > 0 && cyc == 3) chk({tag, "_k2i_fh"}, fh, 32'h0000_0800);
      if (n > 0 && cyc == 7) chk({tag, "_k4i_fh"}, fh, 32'h0000_1000);
      if (n > 0 && cyc == 9) chk({tag, "_sum_fx"}, fx, 32'h0);
      if (busy) busy_hi++;
      if (step_valid) begin
        if (nvalid == 0) first_sv = cyc;
        else if (cyc - last_sv != 45) gap_bad++;
        last_sv = cyc;
        nvalid++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc != budget) @(negedge clk);
    end
    chk({tag, "_valid_count"}, 32'(nvalid), 32'(n));
    if (n > 0) begin
      chk({tag, "_first_valid_cycle"}, 32'(first_sv), 32'd46);
      chk({tag, "_done_with_last_valid"}, 32'(last_sv), 32'(done_cyc));
    end
    chk({tag, "_valid_gap_errors"}, 32'(gap_bad), 32'd0);
    chk({tag, "_done_count"}, 32'(ndone), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_cyc), (n == 0) ? 32'd1 : 32'(45 * n + 1));
    chk({tag, "_busy_cycles"}, 32'(busy_hi), 32'(45 * n));
    chk({tag, "_x_out"}, x_out, ex);
    chk_tol({tag, "_y_out"}, y_out, ey, tol);
  endtask

  task automatic run_case(input vec_t v, input string tag);
    @(negedge clk);
    x0 = v.x0; y0 = v.y0; n_steps = v.n; force_neg = v.neg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    monitor_run(tag, v.x0, v.y0, int'(v.n), v.ex, v.ey, v.tol);
  endtask

  initial begin
    int sv_cnt, dn_cnt, bz_cnt;
    vec_t rv;

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; force_neg = 1'b0;
    x0 = '0; y0 = '0; n_steps = '0;

    vecs[0] = '{32'h0002_0000, 32'h0000_0000, 16'd16, 1'b0, 32'h0003_0000, 32'h0001_0000, 4};
    vecs[1] = '{32'h0000_0000, 32'h0001_0000, 16'd1,  1'b0, 32'h0000_1000, 32'h0000_F85F, 4};
    vecs[2] = '{32'h0005_0000, 32'h0007_0000, 16'd0,  1'b0, 32'h0005_0000, 32'h0007_0000, 0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 16'd1,  1'b1, 32'h0000_1000, 32'hFFFF_F000, 0};
    vecs[4] = '{32'h7FFF_F000, 32'h0000_0000, 16'd1,  1'b1, 32'h8000_0000, 32'hFFFF_F000, 0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 16'd2,  1'b0, 32'h0000_2000, 32'h0000_00FA, 4};

    // Reset state, with start and abort asserted to show reset dominates.
    repeat (2) @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_step_valid", {31'b0, step_valid}, 32'd0);
    chk("rst_x_out", x_out, 32'h0);
    chk("rst_y_out", y_out, 32'h0);
    chk("rst_fx", fx, 32'h0);
    chk("rst_fh", fh, 32'h0);
    start = 1'b0; abort = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_case(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort together with start in IDLE: start wins. Later start while busy is ignored.
    @(negedge clk);
    force_neg = 1'b0; x0 = 32'h0002_0000; y0 = 32'h0; n_steps = 16'd4;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_idle_start_busy", {31'b0, busy}, 32'd1);
    sv_cnt = 0; dn_cnt = 0; bz_cnt = 0;
    for (int c = 1; c <= 65; c++) begin
      if (step_valid) sv_cnt++;
      if (done) dn_cnt++;
      if (c == 46) begin
        chk("abort_step1_valid", {31'b0, step_valid}, 32'd1);
        chk("abort_step1_x", x_out, 32'h0002_1000);
        chk("abort_step1_y", y_out, 32'h0000_1000);
      end
      if (c == 10) begin start = 1'b1; x0 = 32'h1234_0000; n_steps = 16'd9; end
      if (c == 11) start = 1'b0;
      if (c == 65) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    chk("abort_busy_low", {31'b0, busy}, 32'd0);
    chk("abort_no_done", {31'b0, done}, 32'd0);
    chk("abort_no_valid", {31'b0, step_valid}, 32'd0);
    chk("abort_hold_x", x_out, 32'h0002_1000);
    chk("abort_hold_y", y_out, 32'h0000_1000);
    chk("abort_pre_valid_count", 32'(sv_cnt), 32'd1);
    chk("abort_pre_done_count", 32'(dn_cnt), 32'd0);
    sv_cnt = 0; dn_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (step_valid) sv_cnt++;
      if (done) dn_cnt++;
      if (busy) bz_cnt++;
    end
    chk("abort_post_activity", 32'(sv_cnt + dn_cnt + bz_cnt), 32'd0);
    rv = '{32'h0002_0000, 32'h0000_0000, 16'd1, 1'b0, 32'h0002_1000, 32'h0000_1000, 0};
    run_case(rv, "after_abort");

    // Reset asserted during DIV with start held high throughout.
    @(negedge clk);
    force_neg = 1'b0; x0 = 32'h0; y0 = 32'h0001_0000; n_steps = 16'd2; start = 1'b1;
    repeat (20) @(negedge clk);
    reset_n = 1'b0; n_steps = 16'd1;
    sv_cnt = 0; dn_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (step_valid) sv_cnt++;
      if (done) dn_cnt++;
    end
    chk("div_rst_busy", {31'b0, busy}, 32'd0);
    chk("div_rst_x_out", x_out, 32'h0);
    chk("div_rst_y_out", y_out, 32'h0);
    chk("div_rst_fy", fy, 32'h0);
    chk("div_rst_fk", fk, 32'h0);
    chk("div_rst_pulses", 32'(sv_cnt + dn_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    monitor_run("rst_rerun", 32'h0, 32'h0001_0000, 1, 32'h0000_1000, 32'h0000_F85F, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rk4_controller.md
RK4_CONTROLLER -- requirements
Module: rk4_controller

Interface
REQ-001 Parameter: n, 32, data width of all signed Q16.16 two's-complement values.
REQ-002 Parameter: H_SHIFT, 4, step size h = 2^-H_SHIFT (legal 1..8); h in Q16.16 = 1 << (16-H_SHIFT).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 start  input  1  start request; sampled only in IDLE.
REQ-006 abort  input  1  synchronous abort of a run in progress.
REQ-007 x0, y0  input  n each  initial x and y; captured when start is accepted.
REQ-008 n_steps  input  16  number of RK4 steps; captured when start is accepted.
REQ-009 fx, fy, fh, fk  output  n each  operands to the shared evaluator computing f = (fx + fh - fy - fk)/2.
REQ-010 f_dydx  input  n  evaluator result; combinational from fx/fy/fh/fk.
REQ-011 x_out, y_out  output  n each  registered current solution point.
REQ-012 step_valid  output  1  one-cycle pulse when x_out/y_out holds a newly completed step.
REQ-013 busy  output  1  high from the cycle after start is accepted until run end.
REQ-014 done  output  1  one-cycle pulse at normal run completion.

Function
REQ-015 States: IDLE, K1I, K1C, K2I, K2C, K3I, K3C, K4I, K4C, SUM, DIV, UPDATE.
REQ-016 IDLE with start=1 shall capture x0, y0, n_steps; n_steps=0 -> stay IDLE, load x_out=x0, y_out=y0, pulse done next cycle, no step_valid; else -> K1I.
REQ-017 start while busy shall be ignored.
REQ-018 Each KiI cycle shall drive fx/fy/fh/fk from registers; the following KiC cycle shall hold them and capture f_dydx into ki.
REQ-019 Operands: k1: fh=0, fk=0; k2: fh=h>>>1, fk=k1>>>(H_SHIFT+1); k3: fh=h>>>1, fk=k2>>>(H_SHIFT+1); k4: fh=h, fk=k3>>>H_SHIFT; always fx=x, fy=y of current step.
REQ-020 Outside KiI/KiC, fx/fy/fh/fk shall be 0.
REQ-021 SUM (1 cycle): S = k1 + 2*k2 + 2*k3 + k4 in 35-bit signed, no overflow; then T = S>>>H_SHIFT.
REQ-022 DIV: sequential restoring divide of |T| by 6, one quotient bit per cycle, exactly 35 cycles; quotient negated if T<0 (truncate toward zero) giving delta.
REQ-023 UPDATE (1 cycle): y = y + delta[n-1:0] (wraps mod 2^n), x = x + h (wraps), remaining step count decremented.
REQ-024 Cycle after UPDATE: x_out/y_out show new x/y and step_valid=1; next state K1I if steps remain, else IDLE with done=1 and busy=0 in that same cycle.
REQ-025 Per-step latency fixed at 45 cycles (8 eval + 1 SUM + 35 DIV + 1 UPDATE); first step_valid 46 cycles after the edge accepting start; subsequent pulses every 45 cycles.
REQ-026 abort=1 in any non-IDLE state -> IDLE next cycle, busy=0, no done, no step_valid; x_out/y_out retain last completed step.
REQ-027 abort in IDLE shall have no effect; abort and start together in IDLE: start wins.
REQ-028 x_out/y_out shall change only in the cycle after UPDATE or at n_steps=0 acceptance.

Reset
REQ-029 reset_n=0 on a rising edge -> IDLE; x_out, y_out, k1..k4, step count, divider state = 0; fx/fy/fh/fk = 0; busy, done, step_valid = 0.
REQ-030 Reset mid-run shall discard all progress, with no done or step_valid pulse.
REQ-031 Reset shall dominate start and abort.

Verification
REQ-032 Exact-solution check: evaluator f=(x-y)/2, x0=0x00020000, y0=0, n_steps=16, H_SHIFT=4 -> 16 step_valid pulses 45 cycles apart, final x_out=0x00030000, y_out=0x00010000 within 4 LSB, one done.
REQ-033 Single step: x0=0, y0=0x00010000, n_steps=1 -> step_valid 46 cycles after start, y_out=0x0000F85F within 4 LSB, x_out=0x00001000, done same cycle.
REQ-034 n_steps=0, x0=0x00050000, y0=0x00070000 -> done next cycle, x_out/y_out equal inputs, busy never high, no step_valid.
REQ-035 Abort at cycle 20 of step 2 with n_steps=4 -> busy low next cycle, no done, outputs hold step-1 result; a new start then runs normally.
REQ-036 Negative-slope rounding: evaluator forced to return 0xFFFF0000 (-1.0) constantly, y0=0, n_steps=1 -> T=-0x00006000, delta=-0x00001000, y_out=0xFFFFF000.
REQ-037 reset_n low during DIV, start held high throughout -> IDLE with all outputs 0; first start after reset_n release accepted and completes normally.
